// File: rtl/ex_result_stage.sv
// ex_result_stage
//   Execute-stage back end downstream of the 16-bit ALU. Resolves set-condition
//   instructions (SEQ/SLT/SLE/SCO) and conditional branches from the ALU result
//   and flags, maintains the architectural {N,Z,P,CO} flag register, and hands
//   each resolved transaction to the memory stage through a 2-entry
//   valid/ready buffer.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready       upstream handshake; in_ready depends only on state
//   alu_result, alu_n/z/p/co  ALU result (treated as A-B for compares) and flags
//   op_a_msb, op_b_msb        operand sign bits for the signed less-than
//   cond_op                   resolve op: 0 PASS, 1 SEQ, 2 SLT, 3 SLE, 4 SCO,
//                             5 BEQZ, 6 BNEZ, 7 BLTZ, 8 BGEZ, others PASS
//   in_dest, in_wr_en         destination register and write request
//   in_flag_we                load the flag register when accepted
//   out_valid / out_ready     downstream handshake for the head entry
//   out_data, out_dest,
//   out_wr_en, out_taken      resolved head entry
//   flags_q                   architectural flag register {N,Z,P,CO}

module ex_result_stage #(
    parameter int DATA_W = 16,
    parameter int DEST_W = 3,
    parameter int DEPTH  = 2   // the pointer/count logic only supports 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_p,
    input  logic              alu_co,
    input  logic              op_a_msb,
    input  logic              op_b_msb,
    input  logic [3:0]        cond_op,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic              in_flag_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_wr_en,
    output logic              out_taken,
    output logic [3:0]        flags_q
);

    typedef enum logic [3:0] {
        OP_PASS = 4'd0,
        OP_SEQ  = 4'd1,
        OP_SLT  = 4'd2,
        OP_SLE  = 4'd3,
        OP_SCO  = 4'd4,
        OP_BEQZ = 4'd5,
        OP_BNEZ = 4'd6,
        OP_BLTZ = 4'd7,
        OP_BGEZ = 4'd8
    } cond_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic              wr_en;
        logic              taken;
    } entry_t;

    localparam logic [1:0] FULL = 2'(DEPTH);

    // ------------------------------------------------------------------
    // Combinational resolution of the incoming ALU transaction
    // ------------------------------------------------------------------
    logic   lt;
    logic   eq;
    entry_t res;

    // With A-B, the N flag gives the wrong answer when the subtraction
    // overflows; that only happens when the operand signs differ, and then
    // A < B exactly when A is the negative one.
    assign lt = (op_a_msb != op_b_msb) ? op_a_msb : alu_n;
    assign eq = alu_z;

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        res.data  = alu_result;
        res.dest  = in_dest;
        res.wr_en = in_wr_en;
        res.taken = 1'b0;
        case (cond_op)
            OP_SEQ:  res.data = {{(DATA_W-1){1'b0}}, eq};
            OP_SLT:  res.data = {{(DATA_W-1){1'b0}}, lt};
            OP_SLE:  res.data = {{(DATA_W-1){1'b0}}, lt | eq};
            OP_SCO:  res.data = {{(DATA_W-1){1'b0}}, alu_co};
            OP_BEQZ: begin res.wr_en = 1'b0; res.taken = alu_z;  end
            OP_BNEZ: begin res.wr_en = 1'b0; res.taken = ~alu_z; end
            OP_BLTZ: begin res.wr_en = 1'b0; res.taken = alu_n;  end
            OP_BGEZ: begin res.wr_en = 1'b0; res.taken = ~alu_n; end
            default: ;  // PASS and reserved encodings
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry circular buffer and flag register
    // ------------------------------------------------------------------
    entry_t     mem_q [DEPTH];
    entry_t     mem_d [DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q,  count_d;
    logic [3:0] flags_d;
    logic       accept;
    logic       pop;
    entry_t     head;

    // in_ready comes straight from the count register, so there is no
    // combinational path from out_ready back upstream.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head      = mem_q[rd_ptr_q];
    assign out_data  = head.data;
    assign out_dest  = head.dest;
    assign out_wr_en = head.wr_en;
    assign out_taken = head.taken;

    always_comb begin
        mem_d = mem_q;
        if (accept) begin
            mem_d[wr_ptr_q] = res;
        end
        // 1-bit pointers wrap 1 -> 0 naturally.
        wr_ptr_d = wr_ptr_q ^ accept;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, accept} - {1'b0, pop};
        flags_d  = (accept && in_flag_we) ? {alu_n, alu_z, alu_p, alu_co} : flags_q;
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            flags_q  <= 4'd0;
            // NOTE: the entry storage is reset too, because the outputs are
            // driven from it directly and must read zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_result;
    logic        alu_n, alu_z, alu_p, alu_co;
    logic        op_a_msb, op_b_msb;
    logic [3:0]  cond_op;
    logic [2:0]  in_dest;
    logic        in_wr_en;
    logic        in_flag_we;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_dest;
    logic        out_wr_en;
    logic        out_taken;
    logic [3:0]  flags_q;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_result_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_p      (alu_p),
        .alu_co     (alu_co),
        .op_a_msb   (op_a_msb),
        .op_b_msb   (op_b_msb),
        .cond_op    (cond_op),
        .in_dest    (in_dest),
        .in_wr_en   (in_wr_en),
        .in_flag_we (in_flag_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_dest   (out_dest),
        .out_wr_en  (out_wr_en),
        .out_taken  (out_taken),
        .flags_q    (flags_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one transaction on the inputs (in_valid=1) without clocking.
    task automatic set_in(input logic [3:0] op, input logic [15:0] res,
                          input logic [3:0] nzpc, input logic a_msb, input logic b_msb,
                          input logic [2:0] dest, input logic wr, input logic fwe);
        in_valid   = 1'b1;
        cond_op    = op;
        alu_result = res;
        {alu_n, alu_z, alu_p, alu_co} = nzpc;
        op_a_msb   = a_msb;
        op_b_msb   = b_msb;
        in_dest    = dest;
        in_wr_en   = wr;
        in_flag_we = fwe;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [15:0] res,
                        input logic [3:0] nzpc, input logic a_msb, input logic b_msb,
                        input logic [2:0] dest, input logic wr, input logic fwe);
        set_in(op, res, nzpc, a_msb, b_msb, dest, wr, fwe);
        tick();
        in_valid = 1'b0;
    endtask

    // Single transaction through an empty buffer: check the resolved head,
    // then pop it and check the buffer is empty again.
    task automatic xact(input string tag, input logic [3:0] op, input logic [15:0] res,
                        input logic [3:0] nzpc, input logic a_msb, input logic b_msb,
                        input logic wr, input logic [15:0] exp_data,
                        input logic exp_wr, input logic exp_taken);
        out_ready = 1'b0;
        push(op, res, nzpc, a_msb, b_msb, 3'd5, wr, 1'b0);
        check({tag, " valid"}, out_valid, 1'b1);
        check({tag, " data"},  out_data,  exp_data);
        check({tag, " wr_en"}, out_wr_en, exp_wr);
        check({tag, " taken"}, out_taken, exp_taken);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " empty"}, out_valid, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_in(4'd0, 16'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        in_valid  = 1'b0;

        // Reset state
        #12;
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_data",  out_data,  16'h0);
        check("rst out_dest",  out_dest,  3'd0);
        check("rst flags",     flags_q,   4'h0);
        rst = 1'b1;
        tick();
        check("post-rst in_ready", in_ready, 1'b1);

        // Basic PASS with one-cycle latency
        push(4'd0, 16'h1234, 4'h0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        check("pass valid", out_valid, 1'b1);
        check("pass data",  out_data,  16'h1234);
        check("pass dest",  out_dest,  3'd3);
        check("pass wr_en", out_wr_en, 1'b1);
        check("pass taken", out_taken, 1'b0);
        tick();
        check("pass hold data", out_data, 16'h1234);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pass popped", out_valid, 1'b0);

        // Set-condition ops. nzpc = {N,Z,P,CO}
        xact("slt ovf",   4'd2, 16'h7FF0, 4'b0010, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        xact("slt n",     4'd2, 16'hFFFE, 4'b1000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        xact("slt pos-a", 4'd2, 16'h8001, 4'b1000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        xact("sle eq",    4'd3, 16'h0000, 4'b0100, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        xact("sle gt",    4'd3, 16'h0003, 4'b0010, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        xact("seq z",     4'd1, 16'h0000, 4'b0100, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        xact("seq nz",    4'd1, 16'h0040, 4'b0010, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        xact("sco 0",     4'd4, 16'h1111, 4'b0010, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        xact("sco 1",     4'd4, 16'hFFFF, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);

        // Branches: wr_en forced low, data passes through
        xact("bnez",      4'd6, 16'h0010, 4'b0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b1);
        xact("bgez neg",  4'd8, 16'hFFF0, 4'b1000, 1'b0, 1'b0, 1'b1, 16'hFFF0, 1'b0, 1'b0);
        xact("beqz",      4'd5, 16'h0000, 4'b0100, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        xact("bltz",      4'd7, 16'h8000, 4'b1000, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        xact("reserved",  4'd12, 16'hBEEF, 4'b1001, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0);

        // Fill to two entries, back-pressure, ordered drain
        out_ready = 1'b0;
        push(4'd0, 16'hAAAA, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        check("fill1 in_ready", in_ready, 1'b1);
        push(4'd0, 16'h5555, 4'h0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        check("fill2 in_ready", in_ready, 1'b0);
        push(4'd0, 16'h7777, 4'h0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        check("full ignore in_ready", in_ready, 1'b0);
        check("full head data", out_data, 16'hAAAA);
        out_ready = 1'b1;
        check("drain first", out_data, 16'hAAAA);
        tick();
        check("drain in_ready back", in_ready, 1'b1);
        check("drain second valid", out_valid, 1'b1);
        check("drain second data", out_data, 16'h5555);
        check("drain second dest", out_dest, 3'd2);
        tick();
        out_ready = 1'b0;
        check("drain empty", out_valid, 1'b0);

        // Simultaneous accept and pop at count=1, across pointer wrap
        push(4'd0, 16'hC000, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            check("stream head", out_data, 16'hC000 + 16'(i - 1));
            set_in(4'd0, 16'hC000 + 16'(i), 4'h0, 1'b0, 1'b0, 3'(i), 1'b1, 1'b0);
            out_ready = 1'b1;
            tick();
            check("stream valid", out_valid, 1'b1);
            check("stream in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        check("stream last data", out_data, 16'hC005);
        check("stream last dest", out_dest, 3'd5);
        tick();
        out_ready = 1'b0;
        check("stream empty", out_valid, 1'b0);

        // Flag register load / hold, then reset with two entries held
        push(4'd0, 16'h0101, 4'b1001, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1);
        check("flags load", flags_q, 4'b1001);
        push(4'd0, 16'h0202, 4'b0110, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        check("flags hold", flags_q, 4'b1001);
        check("two held in_ready", in_ready, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst flags", flags_q, 4'h0);
        check("midrst out_data", out_data, 16'h0);
        #2;
        rst = 1'b1;
        tick();
        check("rel in_ready", in_ready, 1'b1);
        check("rel out_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
Execute-stage back end that sits directly downstream of the 16-bit ALU. It consumes the ALU result and N/Z/P/CO flags and resolves set-condition instructions (SEQ/SLT/SLE/SCO) and conditional branches. It keeps an architectural flag register and hands each resolved transaction to the memory stage through a 2-entry valid/ready buffer, which decouples ALU timing from memory-stage stalls.

Parameters:
DATA_W, 16, datapath width (ALU result, out_data)
DEST_W, 3, destination register index width
DEPTH, 2, buffer entries (fixed at 2; other values unsupported)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  ALU transaction present
in_ready  output  1  stage can accept (registered, = count != DEPTH)
alu_result  input  DATA_W  ALU result
alu_n, alu_z, alu_p, alu_co  input  1 each  ALU flags
op_a_msb, op_b_msb  input  1 each  sign bits of ALU operands A and B (for signed compare)
cond_op  input  4  resolve op (encoding below)
in_dest  input  DEST_W  destination register
in_wr_en  input  1  instruction writes a register
in_flag_we  input  1  update flag register on accept
out_valid  output  1  head entry valid
out_ready  input  1  memory stage accepts head
out_data  output  DATA_W  resolved write data
out_dest  output  DEST_W  destination register
out_wr_en  output  1  register write enable
out_taken  output  1  branch taken
flags_q  output  4  flag register {N,Z,P,CO}

Behaviour:
- cond_op: 0 PASS, 1 SEQ, 2 SLT, 3 SLE, 4 SCO, 5 BEQZ, 6 BNEZ, 7 BLTZ, 8 BGEZ; 9-15 reserved, treated as PASS.
- ALU result is treated as A-B for the compares. lt = (op_a_msb != op_b_msb) ? op_a_msb : alu_n; eq = alu_z.
- Write data:
  - PASS: alu_result.
  - SEQ/SLT/SLE/SCO: zero-extended 1-bit value of eq / lt / (lt|eq) / alu_co.
  - Branch ops: alu_result.
- taken:
  - BEQZ = alu_z; BNEZ = ~alu_z; BLTZ = alu_n; BGEZ = ~alu_n.
  - 0 for all non-branch ops.
- Write enable: branch ops force out_wr_en=0 regardless of in_wr_en; otherwise out_wr_en=in_wr_en.
- Resolution is combinational at the input. The resolved tuple {data, dest, wr_en, taken} is written into the buffer on accept.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Buffer: 2-entry circular, 1-bit rd/wr pointers, count 0..2.
  - out_* driven from the head entry; out_valid = (count != 0).
  - Latency: accept in cycle T -> out_valid and data visible in T+1 when empty.
- Simultaneous events:
  - Accept and pop in the same cycle: count unchanged, both pointers advance.
  - count=2: in_ready=0, so no accept; a pop in that cycle raises in_ready the next cycle. No combinational path from out_ready to in_ready.
  - Pointers wrap 1 -> 0.
- Flag register: loads {alu_n, alu_z, alu_p, alu_co} on accept with in_flag_we=1; otherwise it holds. Updated at accept time, independent of the pop.
- out_* hold stable while out_valid=1 and out_ready=0.
- Reset (rst=0, async):
  - count, pointers, flags_q = 0; out_valid = 0.
  - Entry storage cleared, so out_data/out_dest/out_wr_en/out_taken read 0.
  - in_ready = 1 after reset release.
  - Reset mid-operation discards all buffered entries; no partial output.
- in_valid while in_ready=0: ignored. Upstream holds the transaction; the stage records nothing.

Test Plan:
- Reset, then PASS alu_result=16'h1234, in_dest=3, in_wr_en=1, accept at T -> out_valid=1 at T+1, out_data=16'h1234, out_dest=3, out_taken=0; out_ready=1 pops, out_valid=0 at T+2.
- SLT with op_a_msb=1, op_b_msb=0, alu_n=0 (overflowed subtract) -> out_data=16'h0001. Same case with SLE and alu_z=1 -> 16'h0001. SCO with alu_co=0 -> 16'h0000.
- BNEZ with alu_z=0, in_wr_en=1 -> out_taken=1, out_wr_en=0. BGEZ with alu_n=1 -> out_taken=0.
- Hold out_ready=0, push 0xAAAA then 0x5555 -> in_ready=0 after the second accept. Third in_valid is ignored. Pop -> 0xAAAA then 0x5555 in order; in_ready returns to 1 the cycle after the first pop.
- count=1 with simultaneous accept and pop, repeated 5 times across pointer wrap -> count stays 1 and the data sequence is preserved with no drops or duplicates.
- Accept with in_flag_we=1, flags {1,0,0,1} -> flags_q=4'b1001. Next accept with in_flag_we=0 -> flags_q unchanged. Assert rst mid-stream with 2 entries held -> out_valid=0 and flags_q=0 immediately, in_ready=1 after release.
